// File: rtl/lcd_pkg.sv
// Shared types and constants for the LCD message arbiter.
package lcd_pkg;

    localparam int LCD_CHARS = 32;
    localparam logic [7:0] CHAR_SPACE = 8'h20;

    typedef logic [7:0] char_t;
    typedef char_t [LCD_CHARS-1:0] frame_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        UPDATE = 2'd1,
        WAIT   = 2'd2,
        HOLD   = 2'd3
    } state_t;

    // Convert a one-hot vector (up to 8 bits) into its bit index; zero input yields 0.
    function automatic logic [2:0] onehot_to_idx(input logic [7:0] oh);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            idx = idx | (oh[i] ? 3'(i) : 3'd0);
        end
        return idx;
    endfunction

endpackage

// File: rtl/lcd_msg_arbiter_chk.sv
// Protocol checks on the arbiter outputs: ownership, done ownership, update pulse width.
module lcd_msg_arbiter_chk #(
    parameter int N_REQ = 3
) (
    input logic             clk,
    input logic             reset,
    input logic [N_REQ-1:0] grant,
    input logic [N_REQ-1:0] done,
    input logic             lcd_update
);

    // At most one requester owns the display at any time.
    a_grant_onehot: assert property (@(posedge clk) disable iff (!reset)
        $onehot0(grant));

    // done goes only to the requester that owned the display on the previous cycle
    // (grant is cleared on the same edge that raises done).
    a_done_owner: assert property (@(posedge clk) disable iff (!reset)
        (done & ~$past(grant)) == '0);

    // lcd_update is always a single-cycle pulse.
    a_update_single: assert property (@(posedge clk) disable iff (!reset)
        !(lcd_update && $past(lcd_update)));

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin winner selection: first active request at or above ptr, wrapping to 0.
module rr_arbiter #(
    parameter int N_REQ = 3,
    parameter int PTR_W = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N_REQ-1:0] winner
);

    logic [PTR_W:0]   sum_s;
    logic [PTR_W-1:0] idx_s;
    logic             found_s;

    // Walk the requesters starting at ptr and mark the first one that is requesting.
    always_comb begin
        winner  = '0;
        found_s = 1'b0;
        sum_s   = '0;
        idx_s   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            sum_s = {1'b0, ptr} + (PTR_W+1)'(i);
            idx_s = (sum_s >= (PTR_W+1)'(N_REQ)) ? PTR_W'(sum_s - (PTR_W+1)'(N_REQ))
                                                 : PTR_W'(sum_s);
            if (!found_s && req[idx_s]) begin
                winner[idx_s] = 1'b1;
                found_s       = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
    end

endmodule

// File: rtl/lcd_msg_arbiter.sv
// Shares one 2x16 LCD between N_REQ message sources: round-robin grant, latch the
// owner's frame, hand it to the LCD driver, then hold it for HOLD_CYCLES clocks.
module lcd_msg_arbiter
    import lcd_pkg::*;
#(
    parameter int N_REQ       = 3,
    parameter int HOLD_CYCLES = 50_000_000
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic [N_REQ-1:0]                    req,
    input  logic [N_REQ-1:0][LCD_CHARS-1:0][7:0] msg,
    output logic [N_REQ-1:0]                    grant,
    output logic [N_REQ-1:0]                    done,
    output logic [LCD_CHARS-1:0][7:0]           lcd_ascii,
    output logic                                lcd_update,
    input  logic                                lcd_busy
);

    localparam int PTR_W = $clog2(N_REQ);
    localparam int CNT_W = $clog2(HOLD_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(N_REQ - 1);

    state_t           state_r;
    logic [PTR_W-1:0] ptr_r;
    logic [PTR_W-1:0] owner_r;
    logic [CNT_W-1:0] cnt_r;
    logic             wait_skip_r;
    logic [N_REQ-1:0] winner_s;
    logic [PTR_W-1:0] win_idx_s;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .PTR_W (PTR_W)
    ) u_rr (
        .req    (req),
        .ptr    (ptr_r),
        .winner (winner_s)
    );

    assign win_idx_s = PTR_W'(onehot_to_idx(8'(winner_s)));

    // Arbitration FSM; every output is a register updated here.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r     <= IDLE;
            ptr_r       <= '0;
            owner_r     <= '0;
            cnt_r       <= '0;
            wait_skip_r <= 1'b0;
            grant       <= '0;
            done        <= '0;
            lcd_update  <= 1'b0;
            lcd_ascii   <= {LCD_CHARS{CHAR_SPACE}};
        end else begin
            lcd_update <= 1'b0;
            done       <= '0;
            case (state_r)
                IDLE: begin
                    if (|req) begin
                        grant     <= winner_s;
                        owner_r   <= win_idx_s;
                        lcd_ascii <= msg[win_idx_s];
                        state_r   <= UPDATE;
                    end else begin
                        grant <= '0;
                    end
                end
                UPDATE: begin
                    if (!lcd_busy) begin
                        lcd_update  <= 1'b1;
                        wait_skip_r <= 1'b1;
                        state_r     <= WAIT;
                    end else begin
                        lcd_update <= 1'b0;
                    end
                end
                WAIT: begin
                    // The driver may take one cycle to raise busy, so ignore it once.
                    if (wait_skip_r) begin
                        wait_skip_r <= 1'b0;
                    end else if (!lcd_busy) begin
                        cnt_r   <= '0;
                        state_r <= HOLD;
                    end else begin
                        state_r <= WAIT;
                    end
                end
                HOLD: begin
                    if (cnt_r == CNT_LAST) begin
                        done    <= grant;
                        grant   <= '0;
                        ptr_r   <= (owner_r == PTR_LAST) ? '0 : owner_r + PTR_W'(1);
                        state_r <= IDLE;
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                default: begin
                    grant   <= '0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/lcd_msg_arbiter.md
LCD_MSG_ARBITER -- requirements
Module: lcd_msg_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 3, number of message requesters (2..8).
REQ-002 SHALL have parameter HOLD_CYCLES, default 50_000_000, minimum display time per message in clk cycles (1 s at 50 MHz); minimum legal value 2.
REQ-003 SHALL have port clk  input  1  master 50 MHz clock.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port req  input  N_REQ  per-requester display request, level, held until done.
REQ-006 SHALL have port msg  input  N_REQ x 32 x 8  per-requester 32-char ASCII string; index 0-15 line 1, 16-31 line 2.
REQ-007 SHALL have port grant  output  N_REQ  one-hot current owner, all-zero when idle.
REQ-008 SHALL have port done  output  N_REQ  one-cycle pulse to owner at end of its hold period.
REQ-009 SHALL have port lcd_ascii  output  32 x 8  registered frame buffer presented to the LCD driver.
REQ-010 SHALL have port lcd_update  output  1  one-cycle pulse: frame ready for LCD driver.
REQ-011 SHALL have port lcd_busy  input  1  LCD driver operation in progress (active high); driver asserts it no later than the cycle after lcd_update.

Function
REQ-012 SHALL implement FSM states IDLE, UPDATE, WAIT, HOLD; all outputs registered.
REQ-013 IDLE: when any req bit high, at next edge SHALL set grant to round-robin winner, load lcd_ascii from msg[winner], go to UPDATE; otherwise stay, grant=0.
REQ-014 Round-robin SHALL search from pointer ptr upward with wrap-around N_REQ-1 -> 0; ptr SHALL become winner+1 (mod N_REQ) when done is issued.
REQ-015 UPDATE: if lcd_busy=0, SHALL pulse lcd_update for exactly one cycle and go to WAIT; if lcd_busy=1, SHALL stay with lcd_update=0.
REQ-016 WAIT: SHALL skip the first cycle, then go to HOLD on the first cycle lcd_busy=0; hold counter cleared on entry to HOLD.
REQ-017 HOLD: counter SHALL increment each cycle; at count HOLD_CYCLES-1 SHALL pulse done[winner] one cycle, clear grant the same cycle, go to IDLE.
REQ-018 Counter width SHALL be $clog2(HOLD_CYCLES); no wrap within one hold.
REQ-019 lcd_ascii SHALL change only on the IDLE->UPDATE edge; msg changes while granted SHALL NOT affect the displayed frame.
REQ-020 req deassertion while granted SHALL be ignored; the hold completes and done still pulses.
REQ-021 A single continuously requesting source SHALL be re-granted after one IDLE cycle, reloading its current msg.
REQ-022 Simultaneous done and new req from another source SHALL be arbitrated in the following IDLE cycle with the updated ptr.
REQ-023 With no requests, lcd_ascii SHALL retain the last frame indefinitely.

Reset
REQ-024 On reset low: state=IDLE, grant=0, done=0, lcd_update=0, ptr=0, counter=0, lcd_ascii all 8'h20 (spaces).
REQ-025 Reset mid-operation SHALL abort immediately with no done pulse; requesters re-request after release.

Structure
REQ-026 Package lcd_pkg SHALL hold LCD_CHARS=32, the char_t (8-bit) and frame_t (32 x char_t) typedefs, and the state enum.
REQ-027 Round-robin winner selection SHALL be a sub-module rr_arbiter (req, ptr -> one-hot winner, combinational).

Verification (bench: N_REQ=3, HOLD_CYCLES=4)
REQ-028 req=3'b010, msg[1]="HELLO..." -> grant=010 next cycle, lcd_ascii=msg[1], one lcd_update pulse, done[1] 4 cycles after HOLD entry.
REQ-029 req=3'b111 held from reset -> grant order 001, 010, 100, 001; exactly one done per grant.
REQ-030 lcd_busy held high 10 cycles in UPDATE -> no lcd_update until busy low, then exactly one pulse.
REQ-031 msg[0] changed and req[0] dropped during HOLD -> lcd_ascii unchanged, done[0] still pulses at count 3.
REQ-032 reset asserted during HOLD -> grant=0, done=0, lcd_ascii all 8'h20 asynchronously; ptr=0 after release.
REQ-033 Assertions throughout: grant one-hot or zero, done subset of grant, lcd_update never two consecutive cycles.
